mig_reqq: RTL and testbench

MIG_REQQ -- requirements
Module: mig_reqq

---
 rtl/mig_reqq.sv | 83 ++++++++
 tb/tb_mig_reqq.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mig_reqq.sv
// mig_reqq: MIG request and write-data FWFT queues; define MIG_REQQ_ERR_EN to build sticky overflow/underflow flags on qerr.
module mig_reqq_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter int W = 32
) (
    input  logic         mclk,
    input  logic         mrst,
    input  logic         wen,
    input  logic [W-1:0] wdata,
    output logic         full,
    input  logic         rnext,
    output logic         rqempty,
    output logic [W-1:0] rdata
);
    logic [W-1:0] mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wptr, rptr;
    logic [DEPTH_LOG2:0] cnt;
    logic push, pop;
    assign full = cnt == (DEPTH_LOG2+1)'(2**DEPTH_LOG2);
    assign rqempty = cnt == '0;
    assign push = wen & ~full;
    assign pop = rnext & ~rqempty;
    assign rdata = mem[rptr];
    always_ff @(posedge mclk) begin
        if (mrst) begin
            wptr <= '0;
            rptr <= '0;
            cnt <= '0;
        end else begin
            wptr <= push ? wptr + DEPTH_LOG2'(1) : wptr;
            rptr <= pop ? rptr + DEPTH_LOG2'(1) : rptr;
            cnt <= cnt + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
        end
    end
    // Storage is deliberately not reset; reset only clears pointers and counts.
    always_ff @(posedge mclk) begin
        if (push && !mrst) mem[wptr] <= wdata;
    end
endmodule

module mig_reqq #(
    parameter int REQ_DEPTH_LOG2 = 3,
    parameter int WDQ_DEPTH_LOG2 = 3
) (
    input  logic         mclk,
    input  logic         mrst,
    input  logic         req_wen,
    input  logic [31:0]  req_waddr,
    input  logic         req_wrd_bwt,
    output logic         req_wfull,
    input  logic         wdq_wen,
    input  logic [127:0] wdq_wdata,
    input  logic [15:0]  wdq_wmask,
    output logic         wdq_wfull,
    input  logic         req_rnext,
    output logic         req_rqempty,
    output logic [31:0]  req_qraddr,
    output logic         req_rd_bwt,
    input  logic         wdq_rnext,
    output logic         wdq_rqempty,
    output logic [143:0] wdq_mask_rdata,
    output logic [1:0]   qerr
);
    mig_reqq_fifo #(.DEPTH_LOG2(REQ_DEPTH_LOG2), .W(33)) u_req (
        .mclk(mclk), .mrst(mrst),
        .wen(req_wen), .wdata({req_wrd_bwt, req_waddr}), .full(req_wfull),
        .rnext(req_rnext), .rqempty(req_rqempty), .rdata({req_rd_bwt, req_qraddr})
    );
    mig_reqq_fifo #(.DEPTH_LOG2(WDQ_DEPTH_LOG2), .W(144)) u_wdq (
        .mclk(mclk), .mrst(mrst),
        .wen(wdq_wen), .wdata({wdq_wmask, wdq_wdata}), .full(wdq_wfull),
        .rnext(wdq_rnext), .rqempty(wdq_rqempty), .rdata(wdq_mask_rdata)
    );
`ifdef MIG_REQQ_ERR_EN
    always_ff @(posedge mclk) begin
        if (mrst) qerr <= '0;
        else qerr <= qerr | {(req_rnext & req_rqempty) | (wdq_rnext & wdq_rqempty),
                             (req_wen & req_wfull) | (wdq_wen & wdq_wfull)};
    end
`else
    assign qerr = '0;
`endif
endmodule

// File: tb/tb_mig_reqq.sv
// tb_mig_reqq: directed self-checking bench for mig_reqq.
module tb_mig_reqq;
    logic mclk = 0, mrst = 1;
    logic req_wen = 0, req_wrd_bwt = 0, req_wfull, req_rnext = 0, req_rqempty, req_rd_bwt;
    logic [31:0] req_waddr = '0, req_qraddr;
    logic wdq_wen = 0, wdq_wfull, wdq_rnext = 0, wdq_rqempty;
    logic [127:0] wdq_wdata = '0;
    logic [15:0] wdq_wmask = '0;
    logic [143:0] wdq_mask_rdata;
    logic [1:0] qerr, exp_err = '0;
    int checks = 0, errors = 0;

    mig_reqq dut (
        .mclk(mclk), .mrst(mrst),
        .req_wen(req_wen), .req_waddr(req_waddr), .req_wrd_bwt(req_wrd_bwt), .req_wfull(req_wfull),
        .wdq_wen(wdq_wen), .wdq_wdata(wdq_wdata), .wdq_wmask(wdq_wmask), .wdq_wfull(wdq_wfull),
        .req_rnext(req_rnext), .req_rqempty(req_rqempty), .req_qraddr(req_qraddr), .req_rd_bwt(req_rd_bwt),
        .wdq_rnext(wdq_rnext), .wdq_rqempty(wdq_rqempty), .wdq_mask_rdata(wdq_mask_rdata), .qerr(qerr)
    );

    always #5 mclk = ~mclk;

    task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge mclk);
        #1;
    endtask

    task automatic overflow;
`ifdef MIG_REQQ_ERR_EN
        exp_err[0] = 1'b1;
`endif
    endtask

    initial begin
        step;
        step;
        mrst = 0;
        check("rst_req_empty", req_rqempty, 1);
        check("rst_wdq_empty", wdq_rqempty, 1);
        check("rst_req_full", req_wfull, 0);
        check("rst_wdq_full", wdq_wfull, 0);
        check("rst_qerr", qerr, 0);
        // single request, visible the cycle after the push
        req_wen = 1; req_waddr = 32'h0000_1000; req_wrd_bwt = 1;
        step;
        req_wen = 0;
        check("one_empty", req_rqempty, 0);
        check("one_addr", req_qraddr, 32'h0000_1000);
        check("one_rd", req_rd_bwt, 1);
        req_rnext = 1;
        step;
        req_rnext = 0;
        check("one_popped", req_rqempty, 1);
        // fill to full, dropped 9th push, in-order drain
        for (int i = 0; i < 8; i++) begin
            req_wen = 1; req_waddr = 32'h2000 + 32'(i) * 32'h100; req_wrd_bwt = i[0];
            step;
            check("fill_full", req_wfull, (i == 7));
        end
        req_waddr = 32'hDEAD;
        step;
        req_wen = 0;
        overflow();
        check("ninth_full", req_wfull, 1);
        check("ninth_qerr", qerr, exp_err);
        for (int i = 0; i < 8; i++) begin
            check("drain_addr", req_qraddr, 32'h2000 + 32'(i) * 32'h100);
            check("drain_rd", req_rd_bwt, i[0]);
            req_rnext = 1;
            step;
            req_rnext = 0;
        end
        check("drain_empty", req_rqempty, 1);
        // full queue: simultaneous push and pop drops the push
        for (int i = 0; i < 8; i++) begin
            req_wen = 1; req_waddr = 32'h3000 + 32'(i); req_wrd_bwt = 0;
            step;
        end
        req_waddr = 32'hBEEF; req_rnext = 1;
        step;
        req_wen = 0; req_rnext = 0;
        overflow();
        check("pp_full", req_wfull, 0);
        check("pp_head", req_qraddr, 32'h3001);
        check("pp_qerr", qerr, exp_err);
        for (int i = 1; i < 8; i++) begin
            check("pp_drain", req_qraddr, 32'h3000 + 32'(i));
            req_rnext = 1;
            step;
            req_rnext = 0;
        end
        check("pp_empty", req_rqempty, 1);
        // underflow pop leaves state unchanged
        req_rnext = 1;
        step;
        req_rnext = 0;
`ifdef MIG_REQQ_ERR_EN
        exp_err[1] = 1'b1;
`endif
        check("udf_empty", req_rqempty, 1);
        check("udf_full", req_wfull, 0);
        check("udf_qerr", qerr, exp_err);
        // write-data queue head and wrap at count 1
        wdq_wen = 1; wdq_wdata = {16{8'hAA}}; wdq_wmask = 16'h000F;
        step;
        wdq_wen = 0;
        check("wdq_empty", wdq_rqempty, 0);
        check("wdq_mask", wdq_mask_rdata[143:128], 16'h000F);
        check("wdq_data", wdq_mask_rdata[127:0], {16{8'hAA}});
        for (int i = 0; i < 20; i++) begin
            wdq_wen = 1; wdq_rnext = 1;
            wdq_wdata = {4{32'hC000_0000 + 32'(i)}}; wdq_wmask = 16'(i + 1);
            step;
            check("wdq_wrap", {wdq_rqempty, wdq_wfull, wdq_mask_rdata},
                  {2'b00, 16'(i + 1), {4{32'hC000_0000 + 32'(i)}}});
        end
        wdq_wen = 0;
        step;
        wdq_rnext = 0;
        check("wdq_drained", wdq_rqempty, 1);
        // reset with entries queued discards everything
        for (int i = 0; i < 8; i++) begin
            req_wen = (i < 5); req_waddr = 32'h4000 + 32'(i);
            wdq_wen = 1; wdq_wdata = 128'(i);
            step;
        end
        req_wen = 0; wdq_wen = 0;
        check("pre_rst_wfull", wdq_wfull, 1);
        check("pre_rst_req", req_rqempty, 0);
        mrst = 1; req_wen = 1; wdq_rnext = 1;
        step;
        mrst = 0; req_wen = 0; wdq_rnext = 0;
        check("mrst_req_empty", req_rqempty, 1);
        check("mrst_wdq_empty", wdq_rqempty, 1);
        check("mrst_wdq_full", wdq_wfull, 0);
        check("mrst_qerr", qerr, 0);
        step;
        check("mrst_push_ignored", req_rqempty, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
